// File: rtl/router_pkg.sv
// Shared constants for the 1x3 packet router datapath: default widths,
// the reserved destination address and header field positions.
package router_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  localparam logic [ADDR_W_DEF-1:0] INVALID_ADDR = 2'b11;

  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;

  // Payload length carried in a header byte.
  function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [DATA_W_DEF-1:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes, the captured parity byte, and
// the mismatch flag compared while the check enable is held.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_hdr_en,
  input  logic [DATA_W-1:0] i_hdr,
  input  logic              i_data_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pkt_load,
  input  logic              i_check,
  output logic              o_err
);

  logic [DATA_W-1:0] r_int_parity;
  logic [DATA_W-1:0] r_pkt_parity;
  logic              r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_parity <= '0;
      r_pkt_parity <= '0;
      r_err        <= 1'b0;
    end else if (i_clr) begin
      r_int_parity <= '0;
      r_pkt_parity <= '0;
      r_err        <= 1'b0;
    end else begin
      if (i_hdr_en)
        r_int_parity <= r_int_parity ^ i_hdr;
      else if (i_data_en)
        r_int_parity <= r_int_parity ^ i_data;
      // The parity byte rides on the data bus in the cycle packet_valid drops.
      if (i_pkt_load)
        r_pkt_parity <= i_data;
      if (i_check)
        r_err <= (r_int_parity != r_pkt_parity);
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: captures the header, steers bytes to the
// destination FIFO (parking one byte while the FIFO is full) and checks parity.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              packet_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic              err
);

  logic [DATA_W-1:0] r_header;
  logic [DATA_W-1:0] r_full_byte;
  logic [DATA_W-1:0] r_dout;
  logic              r_parity_done;
  logic              r_low_pkt_valid;
  logic              w_hdr_ok;
  logic              w_err;

  assign w_hdr_ok = detect_add && packet_valid &&
                    (data_in[ADDR_W-1:0] != ADDR_W'(INVALID_ADDR));

  always_ff @(posedge clk) begin
    if (reset)
      r_header <= '0;
    else if (w_hdr_ok)
      r_header <= data_in;
  end

  // A byte arriving while the FIFO is full is parked and replayed in laf_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout      <= '0;
      r_full_byte <= '0;
    end else if (lfd_state) begin
      r_dout <= r_header;
    end else if (ld_state && !fifo_full) begin
      r_dout <= data_in;
    end else if (ld_state && fifo_full) begin
      r_full_byte <= data_in;
    end else if (laf_state) begin
      r_dout <= r_full_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_low_pkt_valid <= 1'b0;
    else if (detect_add || rst_int_reg)
      r_low_pkt_valid <= 1'b0;
    else if (ld_state && !packet_valid)
      r_low_pkt_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_parity_done <= 1'b0;
    else if (detect_add)
      r_parity_done <= 1'b0;
    else if ((ld_state && !fifo_full && !packet_valid) ||
             (laf_state && r_low_pkt_valid && !r_parity_done))
      r_parity_done <= 1'b1;
  end

  router_parity_acc #(
    .DATA_W(DATA_W)
  ) u_parity (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (detect_add),
    .i_hdr_en  (lfd_state),
    .i_hdr     (r_header),
    .i_data_en (ld_state && packet_valid && !full_state),
    .i_data    (data_in),
    .i_pkt_load(ld_state && !packet_valid),
    .i_check   (r_parity_done),
    .o_err     (w_err)
  );

  assign dout             = r_dout;
  assign parity_done      = r_parity_done;
  assign low_packet_valid = r_low_pkt_valid;
  assign err              = w_err;

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: FSM strobes are driven directly, the
// expected dout stream is queued as stimulus goes in and popped as it appears.
module tb_router_reg;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_DET  = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_CHK  = 6'b000001;

  logic       clk = 1'b0;
  logic       reset;
  logic       packet_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_packet_valid, err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  router_reg dut (
    .clk             (clk),
    .reset           (reset),
    .packet_valid    (packet_valid),
    .data_in         (data_in),
    .fifo_full       (fifo_full),
    .detect_add      (detect_add),
    .lfd_state       (lfd_state),
    .ld_state        (ld_state),
    .laf_state       (laf_state),
    .full_state      (full_state),
    .rst_int_reg     (rst_int_reg),
    .dout            (dout),
    .parity_done     (parity_done),
    .low_packet_valid(low_packet_valid),
    .err             (err)
  );

  // Scoreboard: every cycle that should update dout consumes one queued byte.
  always @(posedge clk) begin
    if (!reset && (lfd_state || (ld_state && !fifo_full) || laf_state)) begin
      #1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL dout_stream: got %02h, no byte expected", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          miscompares++;
          $display("FAIL dout_stream: got %02h, want %02h", dout, e);
        end else
          $display("dout_stream ok: %02h", dout);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic [5:0] s, input logic pv, input logic [7:0] d, input logic ff);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = s;
    packet_valid = pv;
    data_in      = d;
    fifo_full    = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] par, input string name);
    logic exp_err;
    exp_err = ((hdr ^ p0 ^ p1 ^ p2) != par);
    cyc(S_DET, 1'b1, hdr, 1'b0);
    exp_q.push_back(hdr); cyc(S_LFD, 1'b1, hdr, 1'b0);
    exp_q.push_back(p0);  cyc(S_LD, 1'b1, p0, 1'b0);
    exp_q.push_back(p1);  cyc(S_LD, 1'b1, p1, 1'b0);
    exp_q.push_back(p2);  cyc(S_LD, 1'b1, p2, 1'b0);
    exp_q.push_back(par); cyc(S_LD, 1'b0, par, 1'b0);
    vectors++;
    if (parity_done !== 1'b1) begin
      miscompares++; $display("FAIL %s parity_done: got %b want 1", name, parity_done);
    end
    vectors++;
    if (low_packet_valid !== 1'b1) begin
      miscompares++; $display("FAIL %s low_packet_valid: got %b want 1", name, low_packet_valid);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL %s err_early: got %b want 0", name, err);
    end
    cyc(S_CHK, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (err !== exp_err) begin
      miscompares++; $display("FAIL %s err: got %b want %b", name, err, exp_err);
    end
    vectors++;
    if (low_packet_valid !== 1'b0) begin
      miscompares++; $display("FAIL %s lpv_clear: got %b want 0", name, low_packet_valid);
    end
    $display("%s: packet hdr=%02h par=%02h err=%b", name, hdr, par, err);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    vectors++;
    if ({dout, parity_done, low_packet_valid, err} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset_state: got dout=%02h pd=%b lpv=%b err=%b want all 0",
               dout, parity_done, low_packet_valid, err);
    end
    reset = 1'b0;
    $display("test_reset: dout=%02h pd=%b lpv=%b err=%b", dout, parity_done, low_packet_valid, err);
  endtask

  task automatic test_good();
    send_packet(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, "good");
  endtask

  task automatic test_bad_parity();
    send_packet(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C, "bad_parity");
    cyc(S_DET, 1'b1, 8'h0D, 1'b0);
    vectors++;
    if (err !== 1'b0 || parity_done !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_parity_clear: got err=%b pd=%b want 0 0", err, parity_done);
    end
    $display("test_bad_parity: after detect_add err=%b", err);
  endtask

  task automatic test_full_mid();
    cyc(S_DET, 1'b1, 8'h0D, 1'b0);
    exp_q.push_back(8'h0D); cyc(S_LFD, 1'b1, 8'h0D, 1'b0);
    exp_q.push_back(8'h11); cyc(S_LD, 1'b1, 8'h11, 1'b0);
    cyc(S_LD, 1'b1, 8'h22, 1'b1);
    vectors++;
    if (dout !== 8'h11) begin
      miscompares++; $display("FAIL full_mid_hold: got %02h want 11", dout);
    end
    cyc(S_FULL, 1'b1, 8'h22, 1'b1);
    vectors++;
    if (dout !== 8'h11) begin
      miscompares++; $display("FAIL full_mid_hold2: got %02h want 11", dout);
    end
    exp_q.push_back(8'h22); cyc(S_LAF, 1'b1, 8'h22, 1'b0);
    exp_q.push_back(8'h33); cyc(S_LD, 1'b1, 8'h33, 1'b0);
    exp_q.push_back(8'h0D); cyc(S_LD, 1'b0, 8'h0D, 1'b0);
    cyc(S_CHK, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (err !== 1'b0 || parity_done !== 1'b1) begin
      miscompares++; $display("FAIL full_mid_err: got err=%b pd=%b want 0 1", err, parity_done);
    end
    $display("test_full_mid: err=%b", err);
  endtask

  task automatic test_full_parity();
    cyc(S_DET, 1'b1, 8'h0D, 1'b0);
    exp_q.push_back(8'h0D); cyc(S_LFD, 1'b1, 8'h0D, 1'b0);
    exp_q.push_back(8'h11); cyc(S_LD, 1'b1, 8'h11, 1'b0);
    exp_q.push_back(8'h22); cyc(S_LD, 1'b1, 8'h22, 1'b0);
    exp_q.push_back(8'h33); cyc(S_LD, 1'b1, 8'h33, 1'b0);
    cyc(S_LD, 1'b0, 8'h0D, 1'b1);
    vectors++;
    if (low_packet_valid !== 1'b1 || parity_done !== 1'b0 || dout !== 8'h33) begin
      miscompares++;
      $display("FAIL full_parity_park: got lpv=%b pd=%b dout=%02h want 1 0 33",
               low_packet_valid, parity_done, dout);
    end
    cyc(S_FULL, 1'b0, 8'h0D, 1'b1);
    exp_q.push_back(8'h0D); cyc(S_LAF, 1'b0, 8'h0D, 1'b0);
    vectors++;
    if (parity_done !== 1'b1) begin
      miscompares++; $display("FAIL full_parity_done: got %b want 1", parity_done);
    end
    cyc(S_CHK, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL full_parity_err: got %b want 0", err);
    end
    $display("test_full_parity: pd=%b err=%b", parity_done, err);
  endtask

  task automatic test_invalid_addr();
    cyc(S_DET, 1'b1, 8'h21, 1'b0);
    exp_q.push_back(8'h21); cyc(S_LFD, 1'b1, 8'h21, 1'b0);
    cyc(S_DET, 1'b1, 8'h0F, 1'b0);
    vectors++;
    if (dout !== 8'h21) begin
      miscompares++; $display("FAIL invalid_dout: got %02h want 21", dout);
    end
    exp_q.push_back(8'h21); cyc(S_LFD, 1'b1, 8'h0F, 1'b0);
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    $display("test_invalid_addr: dout=%02h", dout);
  endtask

  task automatic test_reset_mid();
    cyc(S_DET, 1'b1, 8'h0D, 1'b0);
    exp_q.push_back(8'h0D); cyc(S_LFD, 1'b1, 8'h0D, 1'b0);
    exp_q.push_back(8'h11); cyc(S_LD, 1'b1, 8'h11, 1'b0);
    reset = 1'b1;
    cyc(S_IDLE, 1'b1, 8'h22, 1'b0);
    vectors++;
    if ({dout, parity_done, low_packet_valid, err} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset_mid_state: got dout=%02h pd=%b lpv=%b err=%b want all 0",
               dout, parity_done, low_packet_valid, err);
    end
    reset = 1'b0;
    $display("test_reset_mid: outputs cleared dout=%02h", dout);
    send_packet(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, "after_reset");
  endtask

  task automatic test_back_to_back();
    send_packet(8'h0E, 8'hA5, 8'h5A, 8'hFF, 8'h0E ^ 8'hA5 ^ 8'h5A ^ 8'hFF, "b2b_a");
    send_packet(8'h11, 8'h01, 8'h02, 8'h04, 8'h00, "b2b_b");
  endtask

  initial begin
    reset = 1'b1;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_IDLE;
    packet_valid = 1'b0;
    data_in      = 8'h00;
    fifo_full    = 1'b0;
    test_reset();
    test_good();
    test_bad_parity();
    test_full_mid();
    test_full_parity();
    test_invalid_addr();
    test_reset_mid();
    test_back_to_back();
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL dout_leftover: got %0d bytes pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
